// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, line/frame strobes, frame count and delayed sync/video flags.
// Define VGA_TIMING_ADDR_EN to build the incremental linear pixel address; otherwise pix_addr is tied to 0.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned SYNC_DLY = 2,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [CNT_W-1:0]  pixel_x,
    output logic [CNT_W-1:0]  pixel_y,
    output logic              line_start,
    output logic              frame_start,
    output logic [7:0]        frame_cnt,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              video_en,
    output logic              hsync,
    output logic              vsync
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned FLAG_W   = 3;

    // Flag bundle is {video, hsync level, vsync level}; idle value is blank with syncs deasserted.
    localparam logic [FLAG_W-1:0] FLAG_RST = {1'b0, ~H_POL, ~V_POL};

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              h_last;
    logic              v_last;
    logic              act;
    logic              hs_on;
    logic              vs_on;
    logic [FLAG_W-1:0] flag_nxt;
    logic [FLAG_W-1:0] flag_r;
    logic [FLAG_W-1:0] flag_out;

    assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));
    assign act    = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    assign hs_on  = (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END));
    assign vs_on  = (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END));

    always_comb begin
        flag_nxt = FLAG_RST;
        flag_nxt = {act, (hs_on ? H_POL : ~H_POL), (vs_on ? V_POL : ~V_POL)};
    end

    // Free-running raster counters; frame_cnt advances on the same edge the raster wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
                v_cnt     <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                v_cnt <= v_cnt + CNT_W'(1);
            end
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // Coordinates, strobes and raw flags all registered from the same counter value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            flag_r      <= FLAG_RST;
        end else begin
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            flag_r      <= flag_nxt;
        end
    end

    // Extra flag latency to line up with the downstream address register + ROM read.
    if (SYNC_DLY == 0) begin : g_dly0
        assign flag_out = flag_r;
    end else if (SYNC_DLY == 1) begin : g_dly1
        logic [FLAG_W-1:0] dly_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dly_q <= FLAG_RST;
            else        dly_q <= flag_r;
        end
        assign flag_out = dly_q;
    end else begin : g_dlyn
        logic [SYNC_DLY-1:0][FLAG_W-1:0] dly_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dly_q <= {SYNC_DLY{FLAG_RST}};
            else        dly_q <= {dly_q[SYNC_DLY-2:0], flag_r};
        end
        assign flag_out = dly_q[SYNC_DLY-1];
    end

    assign video_en = flag_out[2];
    assign hsync    = flag_out[1];
    assign vsync    = flag_out[0];

`ifdef VGA_TIMING_ADDR_EN
    logic [ADDR_W-1:0] addr_cnt;

    // Address tracks the counters: +1 per active pixel, hold in blanking, clear on raster wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
            pix_addr <= '0;
        end else begin
            pix_addr <= addr_cnt;
            if (h_last && v_last) begin
                addr_cnt <= '0;
            end else if (act) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
        end
    end
`else
    assign pix_addr = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so many frames fit in a short run.
// Flags go through a scoreboard queue that models the sync/video delay line.
module tb_vga_timing_gen;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int DLY = 2;
    localparam int CNT_W = 5;
    localparam int ADDR_W = 8;
    localparam bit H_POL = 1'b0;
    localparam bit V_POL = 1'b1;
`ifdef VGA_TIMING_ADDR_EN
    localparam bit ADDR_EN = 1'b1;
`else
    localparam bit ADDR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CNT_W-1:0]  pixel_x;
    logic [CNT_W-1:0]  pixel_y;
    logic              line_start;
    logic              frame_start;
    logic [7:0]        frame_cnt;
    logic [ADDR_W-1:0] pix_addr;
    logic              video_en;
    logic              hsync;
    logic              vsync;

    int         n_checks = 0;
    int         n_pass = 0;
    int         ex;
    int         ey;
    logic [7:0] efc;
    logic [2:0] flag_sb[$];

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(H_POL), .V_POL(V_POL), .SYNC_DLY(DLY),
        .CNT_W(CNT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .line_start(line_start),
        .frame_start(frame_start),
        .frame_cnt(frame_cnt),
        .pix_addr(pix_addr),
        .video_en(video_en),
        .hsync(hsync),
        .vsync(vsync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s at (%0d,%0d) t=%0t: got %0d, expected %0d", tag, ex, ey, $time, got, want);
        end
    endtask

    function automatic logic [2:0] model_flags(input int x, input int y);
        logic act_m;
        logic hs_m;
        logic vs_m;
        act_m = (x < HA) && (y < VA);
        hs_m  = (x >= HA + HF && x < HA + HF + HS) ? H_POL : !H_POL;
        vs_m  = (y >= VA + VF && y < VA + VF + VS) ? V_POL : !V_POL;
        return {act_m, hs_m, vs_m};
    endfunction

    // Address shown at (x,y): raster-order index in the active area, next line's start in h-blank.
    function automatic int exp_addr(input int x, input int y);
        int v;
        if (y >= VA)     v = VA * HA;
        else if (x < HA) v = y * HA + x;
        else             v = (y + 1) * HA;
        return ADDR_EN ? v : 0;
    endfunction

    task automatic model_reset();
        ex  = 0;
        ey  = 0;
        efc = 8'd0;
        flag_sb.delete();
        repeat (DLY) flag_sb.push_back({1'b0, !H_POL, !V_POL});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_px"}, 32'(pixel_x), 32'd0);
        check({tag, "_py"}, 32'(pixel_y), 32'd0);
        check({tag, "_ls"}, 32'(line_start), 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_fc"}, 32'(frame_cnt), 32'd0);
        check({tag, "_addr"}, 32'(pix_addr), 32'd0);
        check({tag, "_ven"}, 32'(video_en), 32'd0);
        check({tag, "_hs"}, 32'(hsync), 32'(!H_POL));
        check({tag, "_vs"}, 32'(vsync), 32'(!V_POL));
    endtask

    task automatic step();
        logic [2:0] f;
        @(posedge clk);
        #1;
        if (ex == HT - 1 && ey == VT - 1) efc = efc + 8'd1;
        check("pixel_x", 32'(pixel_x), 32'(ex));
        check("pixel_y", 32'(pixel_y), 32'(ey));
        check("line_start", 32'(line_start), 32'(ex == 0));
        check("frame_start", 32'(frame_start), 32'(ex == 0 && ey == 0));
        check("frame_cnt", 32'(frame_cnt), 32'(efc));
        check("pix_addr", 32'(pix_addr), 32'(exp_addr(ex, ey)));
        flag_sb.push_back(model_flags(ex, ey));
        f = flag_sb.pop_front();
        check("video_en", 32'(video_en), 32'(f[2]));
        check("hsync", 32'(hsync), 32'(f[1]));
        check("vsync", 32'(vsync), 32'(f[0]));
        if (ex == HT - 1) begin
            ex = 0;
            ey = (ey == VT - 1) ? 0 : ey + 1;
        end else begin
            ex = ex + 1;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset("rst");
        end

        // Release and run past 256 frames so frame_cnt wraps 255 -> 0.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (258 * HT * VT + 20) step();

        // Mid-line asynchronous reset inside the active area.
        for (int i = 0; i < 2 * HT * VT && !(ex == 6 && ey == 2); i++) step();
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset("midrst_hold");
        end

        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * HT * VT + 20) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
